// File: rtl/sb_deser_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sb_deser_fifo
// Brief    : Sideband multi-lane deserializer with a DEPTH-entry frame FIFO.
//            Optional macro SB_DESER_MSB_FIRST_EN selects MSB-first beat order.
// Revision : 1.0
// ============================================================================
module sb_deser_fifo #(
  parameter int WIDTH = 64,
  parameter int LANES = 1,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LANES-1:0]             in_data,
  input  logic                         in_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_data_valid,
  input  logic                         out_data_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  input  logic                         clear_overflow
);

  localparam int BEATS = WIDTH / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int CNTW  = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   LAST_BEAT = CW'(BEATS - 1);
  localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(DEPTH);

  logic [CW-1:0]    beat_q, beat_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] frame;
  logic             push, pop, full, accept, drop;

  // Shift buffer with the current beat merged in; this is the frame pushed
  // when the beat is the last one, so completion costs no extra edge.
  always_comb begin
    frame = shift_q;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_q == k[CW-1:0]) begin
`ifdef SB_DESER_MSB_FIRST_EN
        frame[WIDTH-1-k*LANES -: LANES] = in_data;
`else
        frame[k*LANES +: LANES] = in_data;
`endif
      end
    end
  end

  always_comb begin
    full   = (count_q == FULL_CNT);
    pop    = (count_q != '0) && out_data_ready;
    push   = in_valid && (beat_q == LAST_BEAT);
    accept = push && (!full || pop);
    drop   = push && !accept;

    beat_d  = beat_q;
    shift_d = shift_q;
    if (in_valid) begin
      shift_d = frame;
      beat_d  = (beat_q == LAST_BEAT) ? '0 : beat_q + CW'(1);
    end

    mem_d = mem_q;
    if (accept) begin
      mem_d[wr_q] = frame;
    end
    wr_d = accept ? wr_q + PW'(1) : wr_q;
    rd_d = pop ? rd_q + PW'(1) : rd_q;

    case ({accept, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase

    // A drop on the same edge as a clear keeps the flag set.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      beat_q     <= '0;
      shift_q    <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      beat_q     <= beat_d;
      shift_q    <= shift_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign out_data       = mem_q[rd_q];
  assign out_data_valid = (count_q != '0);
  assign count          = count_q;
  assign overflow       = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sb_deser_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sb_deser_fifo
// Brief    : Directed bench for sb_deser_fifo (1-lane and 4-lane instances).
// Revision : 1.0
// ============================================================================
module tb_sb_deser_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_data, in_valid, out_data_ready, clear_overflow;
  logic [63:0] out_data;
  logic        out_data_valid, overflow;
  logic [2:0]  count;

  logic [3:0]  in4_data;
  logic        in4_valid;
  logic [63:0] out4_data;
  logic        out4_valid, ovf4;
  logic        out4_ready = 1'b0;
  logic        clr4 = 1'b0;
  logic [2:0]  count4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sb_deser_fifo #(.WIDTH(64), .LANES(1), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_data_valid(out_data_valid),
    .out_data_ready(out_data_ready), .count(count),
    .overflow(overflow), .clear_overflow(clear_overflow)
  );

  sb_deser_fifo #(.WIDTH(64), .LANES(4), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_data(in4_data), .in_valid(in4_valid),
    .out_data(out4_data), .out_data_valid(out4_valid),
    .out_data_ready(out4_ready), .count(count4),
    .overflow(ovf4), .clear_overflow(clr4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change after the rising edge; the DUT samples on the falling edge
  // and outputs are observed 1 time unit later.
  task automatic step1(input logic v, input logic b, input logic rdy, input logic clr);
    @(posedge clk);
    in_valid = v; in_data = b; out_data_ready = rdy; clear_overflow = clr;
    in4_valid = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic step4(input logic v, input logic [3:0] nib);
    @(posedge clk);
    in4_valid = v; in4_data = nib;
    in_valid = 1'b0; out_data_ready = 1'b0; clear_overflow = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic send1(input logic [63:0] p, input int nbeats, input logic rdy_last, input logic clr_last);
    for (int i = 0; i < nbeats; i++) begin
      if (i == 63) step1(1'b1, p[i], rdy_last, clr_last);
      else         step1(1'b1, p[i], 1'b0, 1'b0);
    end
  endtask

  localparam logic [63:0] P  = 64'hA5A5_0000_FFFF_1234;
  localparam logic [63:0] F1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] F2 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] F3 = 64'h9999_AAAA_BBBB_CCCC;
  localparam logic [63:0] F4 = 64'hDDDD_EEEE_0123_4567;
  localparam logic [63:0] F5 = 64'h89AB_CDEF_FEDC_BA98;
  localparam logic [63:0] F6 = 64'h0F0F_F0F0_1357_9BDF;
  localparam logic [63:0] F7 = 64'h2468_ACE0_DEAD_BEEF;
  localparam logic [63:0] Q  = 64'hCAFE_F00D_0000_0001;
  localparam logic [63:0] X  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] P2 = 64'h0123_4567_89AB_CDEF;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] p4;
    p4 = P;
    rst = 1'b1; in_data = 1'b0; in_valid = 1'b0; out_data_ready = 1'b0;
    clear_overflow = 1'b0; in4_data = 4'h0; in4_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_data_valid), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_data", out_data, 64'd0);
    rst = 1'b0;

    // Single frame: no valid until the 64th beat.
    send1(P, 63, 1'b0, 1'b0);
    chk("lat_valid_63", 64'(out_data_valid), 64'd0);
    step1(1'b1, P[63], 1'b0, 1'b0);
    chk("lat_valid_64", 64'(out_data_valid), 64'd1);
    chk("lat_data", out_data, P);
    chk("lat_count", 64'(count), 64'd1);
    step1(1'b0, 1'b0, 1'b1, 1'b0);
    chk("pop_count", 64'(count), 64'd0);
    chk("pop_valid", 64'(out_data_valid), 64'd0);

    // Fill to full, then drop.
    send1(F1, 64, 1'b0, 1'b0);
    send1(F2, 64, 1'b0, 1'b0);
    send1(F3, 64, 1'b0, 1'b0);
    send1(F4, 64, 1'b0, 1'b0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_overflow", 64'(overflow), 64'd0);
    send1(F5, 64, 1'b0, 1'b0);
    chk("drop_count", 64'(count), 64'd4);
    chk("drop_overflow", 64'(overflow), 64'd1);
    chk("drop_head", out_data, F1);

    // Drop and clear on the same edge: set wins.
    send1(F6, 64, 1'b0, 1'b1);
    chk("dropclr_overflow", 64'(overflow), 64'd1);
    chk("dropclr_count", 64'(count), 64'd4);
    step1(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_overflow", 64'(overflow), 64'd0);

    // Full FIFO: completion with a pop on the same edge is not a drop.
    send1(F7, 64, 1'b1, 1'b0);
    chk("pp_overflow", 64'(overflow), 64'd0);
    chk("pp_count", 64'(count), 64'd4);
    chk("pp_head", out_data, F2);
    step1(1'b0, 1'b0, 1'b1, 1'b0);
    chk("pop2_head", out_data, F3);
    chk("pop2_count", 64'(count), 64'd3);
    step1(1'b0, 1'b0, 1'b1, 1'b0);
    chk("pop3_head", out_data, F4);
    step1(1'b0, 1'b0, 1'b1, 1'b0);
    chk("pop4_head", out_data, F7);
    chk("pop4_count", 64'(count), 64'd1);
    step1(1'b0, 1'b0, 1'b1, 1'b0);
    chk("pop5_count", 64'(count), 64'd0);
    chk("pop5_valid", 64'(out_data_valid), 64'd0);

    // Reset mid-frame: asynchronous clear, partial frame discarded.
    send1(Q, 64, 1'b0, 1'b0);
    chk("pre_rst_count", 64'(count), 64'd1);
    send1(X, 30, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_valid", 64'(out_data_valid), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send1(P2, 64, 1'b0, 1'b0);
    chk("fresh_count", 64'(count), 64'd1);
    chk("fresh_data", out_data, P2);

    // Four lanes with a 3-edge gap after beat 7.
    for (int k = 0; k < 16; k++) begin
      if (k == 15) chk("l4_valid_15", 64'(out4_valid), 64'd0);
      step4(1'b1, p4[k*4 +: 4]);
      if (k == 7) begin
        for (int g = 0; g < 3; g++) step4(1'b0, 4'hF);
      end
    end
    chk("l4_valid", 64'(out4_valid), 64'd1);
    chk("l4_data", out4_data, P);
    chk("l4_count", 64'(count4), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
